// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state encoding and MISR defaults for the pattern sweeper
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } sweep_state_t;

    localparam int          SIG_W_DEFAULT = 16;
    localparam logic [15:0] POLY_DEFAULT  = 16'h1021;

endpackage

// File: rtl/exhaustive_pattern_sweeper_if.sv
// rtl/exhaustive_pattern_sweeper_if.sv - record stream carrying {pattern, response} to the logger
interface exhaustive_pattern_sweeper_if #(
    parameter int N_IN  = 6,
    parameter int N_OUT = 1
);
    logic             rec_valid;
    logic             rec_ready;
    logic [N_IN-1:0]  rec_pattern;
    logic [N_OUT-1:0] rec_resp;

    modport master (output rec_valid, output rec_pattern, output rec_resp, input rec_ready);
    modport slave  (input rec_valid, input rec_pattern, input rec_resp, output rec_ready);
endinterface

// File: rtl/sweep_misr.sv
// rtl/sweep_misr.sv - multiple-input signature register, also used by the response checker
module sweep_misr
    import sweep_pkg::*;
#(
    parameter int               SIG_W = SIG_W_DEFAULT,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEFAULT)
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    // Seed to all-ones on reset/clear, otherwise shift-with-feedback and fold in din
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            sig <= '1;
        end else if (clear) begin
            sig <= '1;
        end else if (en) begin
            sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ din;
        end
    end

endmodule

// File: rtl/exhaustive_pattern_sweeper.sv
// rtl/exhaustive_pattern_sweeper.sv - drives every input pattern, records responses, builds a signature
module exhaustive_pattern_sweeper
    import sweep_pkg::*;
#(
    parameter int               N_IN   = 6,
    parameter int               N_OUT  = 1,
    parameter int               SETTLE = 1,
    parameter int               SIG_W  = SIG_W_DEFAULT,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY_DEFAULT)
) (
    input  logic                         CK,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    output logic [N_IN-1:0]              pattern_o,
    input  logic [N_OUT-1:0]             resp_i,
    exhaustive_pattern_sweeper_if.master rec,
    output logic                         busy,
    output logic                         done,
    output logic [SIG_W-1:0]             signature
);

    localparam int               CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  LAST_PAT    = '1;

    sweep_state_t     state;
    sweep_state_t     state_nx;
    logic [CNT_W-1:0] settle_cnt;
    logic [N_IN-1:0]  rec_pattern_q;
    logic [N_OUT-1:0] rec_resp_q;
    logic             sweep_start;
    logic             misr_en;
    logic [SIG_W-1:0] misr_din;

    // abort beats start in IDLE; a record accepted on an abort edge is dropped
    assign sweep_start = (state == IDLE) && start && !abort;
    assign misr_en     = (state == EMIT) && rec.rec_ready && !abort;
    assign misr_din    = SIG_W'({rec_pattern_q, rec_resp_q});

    assign rec.rec_pattern = rec_pattern_q;
    assign rec.rec_resp    = rec_resp_q;

    // State register
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and state-decoded outputs; abort overrides everything
    always_comb begin
        state_nx      = state;
        rec.rec_valid = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (sweep_start) state_nx = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (settle_cnt == '0) state_nx = EMIT;
            end
            EMIT: begin
                busy          = 1'b1;
                rec.rec_valid = 1'b1;
                if (rec.rec_ready) state_nx = (pattern_o == LAST_PAT) ? DONE : WAIT;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    // Pattern counter, settle timer and record capture; the sweep stops at all-ones without wrapping
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            pattern_o     <= '0;
            settle_cnt    <= '0;
            rec_pattern_q <= '0;
            rec_resp_q    <= '0;
        end else if (!abort) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pattern_o  <= '0;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                WAIT: begin
                    if (settle_cnt == '0) begin
                        rec_pattern_q <= pattern_o;
                        rec_resp_q    <= resp_i;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                EMIT: begin
                    if (rec.rec_ready && (pattern_o != LAST_PAT)) begin
                        pattern_o  <= pattern_o + N_IN'(1);
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    sweep_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .CK    (CK),
        .reset (reset),
        .clear (sweep_start),
        .en    (misr_en),
        .din   (misr_din),
        .sig   (signature)
    );

endmodule

// File: tb/tb_exhaustive_pattern_sweeper.sv
// tb/tb_exhaustive_pattern_sweeper.sv - self-checking bench for exhaustive_pattern_sweeper
module tb_exhaustive_pattern_sweeper;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    always @(posedge CK) cycle++;

    // DUT A: SETTLE=1, combinational truth-table DUT
    logic        rst_n_a, start_a, abort_a, busy_a, done_a;
    logic [5:0]  pat_a;
    logic        resp_a;
    logic [15:0] sig_a;
    logic [63:0] tt_a;
    exhaustive_pattern_sweeper_if #(.N_IN(6), .N_OUT(1)) if_a ();
    assign resp_a = tt_a[pat_a];

    exhaustive_pattern_sweeper #(.N_IN(6), .N_OUT(1), .SETTLE(1), .SIG_W(16), .POLY(16'h1021)) dut_a (
        .CK(CK), .reset(rst_n_a), .start(start_a), .abort(abort_a),
        .pattern_o(pat_a), .resp_i(resp_a), .rec(if_a.master),
        .busy(busy_a), .done(done_a), .signature(sig_a)
    );

    // DUT B: SETTLE=3, truth-table DUT with a two-cycle response delay
    logic        rst_n_b, start_b, abort_b, busy_b, done_b;
    logic [5:0]  pat_b;
    logic        resp_b;
    logic [15:0] sig_b;
    logic [63:0] tt_b;
    logic [5:0]  pb1 = '0;
    logic [5:0]  pb2 = '0;
    exhaustive_pattern_sweeper_if #(.N_IN(6), .N_OUT(1)) if_b ();
    always @(posedge CK) begin
        pb1 <= pat_b;
        pb2 <= pb1;
    end
    assign resp_b = tt_b[pb2];

    exhaustive_pattern_sweeper #(.N_IN(6), .N_OUT(1), .SETTLE(3), .SIG_W(16), .POLY(16'h1021)) dut_b (
        .CK(CK), .reset(rst_n_b), .start(start_b), .abort(abort_b),
        .pattern_o(pat_b), .resp_i(resp_b), .rec(if_b.master),
        .busy(busy_b), .done(done_b), .signature(sig_b)
    );

    // Accepted-record monitors, sampled on the falling edge
    logic [6:0] q_a[$];
    logic [6:0] q_b[$];
    int         t_b[$];
    int         done_cnt_a = 0;
    always @(negedge CK) begin
        if (rst_n_a && !abort_a && if_a.rec_valid && if_a.rec_ready)
            q_a.push_back({if_a.rec_pattern, if_a.rec_resp});
        if (rst_n_b && !abort_b && if_b.rec_valid && if_b.rec_ready) begin
            q_b.push_back({if_b.rec_pattern, if_b.rec_resp});
            t_b.push_back(cycle);
        end
        if (done_a) done_cnt_a++;
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference signature: polynomial fold of the first n records of an ascending sweep
    function automatic logic [15:0] misr_fold(input int n, input logic [63:0] tt);
        int s = 'hFFFF;
        for (int p = 0; p < n; p++) begin
            s = s * 2;
            if (s >= 65536) s = (s - 65536) ^ 'h1021;
            s = s ^ (p * 2 + int'(tt[p]));
        end
        return s[15:0];
    endfunction

    function automatic logic [63:0] parity_table();
        logic [63:0] t;
        for (int p = 0; p < 64; p++) t[p] = ^(p[5:0]);
        return t;
    endfunction

    task automatic check_records_a(input string tag, input logic [63:0] tt);
        int bad = 0;
        check({tag, "_count"}, q_a.size(), 64);
        for (int i = 0; i < q_a.size() && i < 64; i++)
            if (q_a[i] !== 7'((i << 1) | int'(tt[i]))) bad++;
        check({tag, "_order"}, bad, 0);
    endtask

    task automatic wait_done_a(input string tag, input int limit, output int cyc);
        cyc = 0;
        while (!done_a && cyc < limit) begin
            tick();
            cyc++;
        end
        check({tag, "_done_seen"}, done_a, 1);
    endtask

    task automatic start_sweep_a();
        q_a.delete();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    int          cyc, n, bad, dsnap;
    logic [15:0] sig1;

    initial begin
        rst_n_a = 0; start_a = 0; abort_a = 0; if_a.rec_ready = 1;
        rst_n_b = 0; start_b = 0; abort_b = 0; if_b.rec_ready = 1;
        tt_a = parity_table();
        tt_b = {$urandom, $urandom};
        tick(); tick();

        // Reset state
        check("reset_a_outputs", {pat_a, if_a.rec_valid, busy_a, done_a, if_a.rec_pattern, if_a.rec_resp}, 0);
        check("reset_a_sig", sig_a, 16'hFFFF);
        check("reset_b_sig", sig_b, 16'hFFFF);
        rst_n_a = 1; rst_n_b = 1;
        tick();

        // Test 1: full sweep, parity DUT, ready held high
        start_sweep_a();
        check("t1_first_wait", {busy_a, if_a.rec_valid, pat_a}, {1'b1, 1'b0, 6'd0});
        wait_done_a("t1", 1000, cyc);
        check("t1_done_cycle", cyc, 128);
        check("t1_sig", sig_a, misr_fold(64, tt_a));
        sig1 = sig_a;
        check_records_a("t1", tt_a);
        tick();
        check("t1_done_pulse_width", {done_a, busy_a}, 0);
        tick(); tick();
        check("t1_sig_stable", sig_a, sig1);

        // Test 2: backpressure while pattern 001010 is pending
        start_sweep_a();
        n = 0;
        while (!(busy_a && !if_a.rec_valid && pat_a == 6'd10) && n < 500) begin tick(); n++; end
        check("t2_reach_p10", pat_a, 6'd10);
        if_a.rec_ready = 0;
        bad = 0;
        repeat (5) begin
            tick();
            if (!(if_a.rec_valid && if_a.rec_pattern == 6'd10 && pat_a == 6'd10 && if_a.rec_resp == tt_a[10])) bad++;
        end
        check("t2_held_stable", bad, 0);
        check("t2_no_accept_during_stall", q_a.size(), 10);
        if_a.rec_ready = 1;
        wait_done_a("t2", 1000, cyc);
        check_records_a("t2", tt_a);
        check("t2_sig_same_as_t1", sig_a, sig1);
        tick();

        // Test 3: DUT B, SETTLE=3 with a delayed response
        q_b.delete(); t_b.delete();
        start_b = 1; tick(); start_b = 0;
        cyc = 0;
        while (!done_b && cyc < 2000) begin tick(); cyc++; end
        check("t3_done_cycle", cyc, 256);
        bad = 0;
        for (int i = 0; i < q_b.size() && i < 64; i++)
            if (q_b[i] !== 7'((i << 1) | int'(tt_b[i]))) bad++;
        check("t3_count", q_b.size(), 64);
        check("t3_records", bad, 0);
        bad = 0;
        for (int i = 1; i < t_b.size(); i++) if (t_b[i] - t_b[i-1] != 4) bad++;
        check("t3_period4", bad, 0);
        check("t3_sig", sig_b, misr_fold(64, tt_b));

        // Test 4: abort while EMIT holds pattern 100000
        tt_a = {$urandom, $urandom};
        start_sweep_a();
        n = 0;
        while (!(if_a.rec_valid && if_a.rec_pattern == 6'd32) && n < 500) begin tick(); n++; end
        dsnap = done_cnt_a;
        abort_a = 1;
        tick();
        abort_a = 0;
        check("t4_idle_after_abort", {if_a.rec_valid, busy_a, done_a}, 0);
        check("t4_partial_sig", sig_a, misr_fold(32, tt_a));
        check("t4_partial_count", q_a.size(), 32);
        repeat (5) tick();
        check("t4_no_done", done_cnt_a - dsnap, 0);
        start_sweep_a();
        check("t4_restart_state", {busy_a, pat_a}, {1'b1, 6'd0});
        check("t4_restart_seed", sig_a, 16'hFFFF);
        wait_done_a("t4", 1000, cyc);
        check_records_a("t4", tt_a);
        check("t4_sig", sig_a, misr_fold(64, tt_a));
        tick();

        // Test 5: start during busy with random backpressure, then start+abort in IDLE
        tt_a = {$urandom, $urandom};
        dsnap = done_cnt_a;
        start_sweep_a();
        n = 0;
        while (!done_a && n < 3000) begin
            if_a.rec_ready = ($urandom_range(0, 3) != 0);
            start_a = (n == 40);
            tick();
            n++;
        end
        start_a = 0;
        if_a.rec_ready = 1;
        check("t5_done_seen", done_a, 1);
        tick(); tick();
        check("t5_single_done", done_cnt_a - dsnap, 1);
        check_records_a("t5", tt_a);
        check("t5_sig", sig_a, misr_fold(64, tt_a));
        start_a = 1; abort_a = 1;
        tick();
        start_a = 0; abort_a = 0;
        check("t5_start_abort_idle", {busy_a, if_a.rec_valid, pat_a}, {1'b0, 1'b0, 6'd63});
        tick();
        check("t5_still_idle", busy_a, 0);

        // Test 6: asynchronous reset in the middle of WAIT
        tt_a = {$urandom, $urandom};
        start_sweep_a();
        n = 0;
        while (!(busy_a && !if_a.rec_valid && pat_a == 6'd5) && n < 500) begin tick(); n++; end
        dsnap = done_cnt_a;
        rst_n_a = 0;
        #1;
        check("t6_async_outputs", {pat_a, if_a.rec_valid, busy_a, done_a, if_a.rec_pattern, if_a.rec_resp}, 0);
        check("t6_async_sig", sig_a, 16'hFFFF);
        tick(); tick();
        rst_n_a = 1;
        tick(); tick(); tick();
        check("t6_idle_without_start", {busy_a, done_cnt_a - dsnap}, 0);
        start_sweep_a();
        wait_done_a("t6", 1000, cyc);
        check("t6_done_cycle", cyc, 128);
        check_records_a("t6", tt_a);
        check("t6_sig", sig_a, misr_fold(64, tt_a));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
